// File: rtl/dose_sched_pkg.sv
// Shared types for the dose scheduler: FSM state encoding, countdown width and
// the per-slot prescription record.
package dose_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALERT = 2'd2
    } state_e;

    // Wide enough for 15 units of 3600 seconds.
    localparam int CNT_W      = 17;
    localparam int SLOT_ID_W  = 8;
    localparam int SLOT_INT_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_ID_W-1:0]  id;
        logic [SLOT_INT_W-1:0] interval;
        logic [CNT_W-1:0]      countdown;
        logic                  due;
    } slot_t;

endpackage

// File: rtl/dose_rr_arbiter.sv
// Combinational round-robin pick among due slots, searching from last_i+1
// upward with wrap-around.
module dose_rr_arbiter
    import dose_sched_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_i,
    output logic                 grant_valid_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

    logic [IDX_W-1:0] cand_s;

    // First requester after last_i wins; NUM_SLOTS is a power of two so the index wraps naturally.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand_s        = '0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            cand_s = last_i + IDX_W'(k);
            if (!grant_valid_o && req_i[cand_s]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand_s;
            end else begin
                grant_valid_o = grant_valid_o;
            end
        end
    end

endmodule

// File: rtl/dose_scheduler.sv
// Multi-slot prescription scheduler with round-robin alarm presentation.
// Optional missed-dose counter and port enabled by DOSE_SCHED_MISSED_EN.
module dose_scheduler
    import dose_sched_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int ID_W          = 4,
    parameter int INT_W         = 4,
    parameter int SEC_PER_UNIT  = 3600,
    parameter int ALERT_TIMEOUT = 300
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick_1s,
    input  logic                         load,
    input  logic [$clog2(NUM_SLOTS)-1:0] load_slot,
    input  logic [ID_W-1:0]              load_id,
    input  logic [INT_W-1:0]             load_int,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         ack,
    output logic                         running,
    output logic                         alarm,
    output logic [ID_W-1:0]              alarm_id,
    output logic [$clog2(NUM_SLOTS)-1:0] alarm_slot,
    output logic [NUM_SLOTS-1:0]         due_mask
`ifdef DOSE_SCHED_MISSED_EN
    ,
    output logic [7:0]                   missed_count
`endif
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int TO_W  = $clog2(ALERT_TIMEOUT + 1);

    localparam logic [1:0]      ST_IDLE  = IDLE;
    localparam logic [1:0]      ST_RUN   = RUN;
    localparam logic [1:0]      ST_ALERT = ALERT;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ALERT_TIMEOUT - 1);

    logic [1:0]           state_q, state_d;
    slot_t                slots_q [NUM_SLOTS];
    slot_t                slots_d [NUM_SLOTS];
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [ID_W-1:0]      alarm_id_q, alarm_id_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 running_q, alarm_q;

    logic [NUM_SLOTS-1:0] due_s, clr_s;
    logic                 grant_valid_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic                 active_s, tick_en_s, ack_en_s, timeout_s, any_valid_s;

`ifdef DOSE_SCHED_MISSED_EN
    logic [7:0]           inc_s, missed_q, missed_d;
    logic [8:0]           miss_sum_s;
`endif

    function automatic logic [CNT_W-1:0] reload_of(input logic [SLOT_INT_W-1:0] iv);
        reload_of = CNT_W'(iv) * CNT_W'(SEC_PER_UNIT);
    endfunction

    // Collect per-slot due flags for the arbiter and the due_mask output.
    always_comb begin
        due_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            due_s[i] = slots_q[i].due;
        end
    end

    dose_rr_arbiter #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_arb (
        .req_i         (due_s),
        .last_i        (last_q),
        .grant_valid_o (grant_valid_s),
        .grant_idx_o   (grant_idx_s)
    );

    // Event qualification: stop overrides tick, ack and timeout; ack beats a coincident timeout.
    always_comb begin
        active_s  = (state_q == ST_RUN) || (state_q == ST_ALERT);
        tick_en_s = tick_1s && active_s && !stop;
        ack_en_s  = ack && (state_q == ST_ALERT) && !stop;
        timeout_s = tick_1s && (state_q == ST_ALERT) && !stop && !ack && (to_cnt_q == TO_LAST);
        clr_s     = '0;
        if (ack_en_s || timeout_s) begin
            clr_s[win_q] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Slot table update: load in IDLE, countdown and due on ticks. A due set by this tick survives a clear.
    always_comb begin
        slots_d     = slots_q;
        any_valid_s = 1'b0;
`ifdef DOSE_SCHED_MISSED_EN
        inc_s       = 8'd0;
`endif
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (load && (state_q == ST_IDLE) && (load_slot == IDX_W'(i))) begin
                slots_d[i].valid     = (load_int != '0);
                slots_d[i].id        = SLOT_ID_W'(load_id);
                slots_d[i].interval  = SLOT_INT_W'(load_int);
                slots_d[i].countdown = reload_of(SLOT_INT_W'(load_int));
                slots_d[i].due       = 1'b0;
            end else if (tick_en_s && slots_q[i].valid) begin
                if (slots_q[i].countdown > CNT_W'(1)) begin
                    slots_d[i].countdown = slots_q[i].countdown - CNT_W'(1);
                    slots_d[i].due       = slots_q[i].due & ~clr_s[i];
                end else begin
                    slots_d[i].countdown = reload_of(slots_q[i].interval);
                    slots_d[i].due       = 1'b1;
`ifdef DOSE_SCHED_MISSED_EN
                    if (slots_q[i].due && !clr_s[i]) begin
                        inc_s = inc_s + 8'd1;
                    end else begin
                        inc_s = inc_s;
                    end
`endif
                end
            end else begin
                slots_d[i].due = slots_q[i].due & ~clr_s[i];
            end
            any_valid_s = any_valid_s | slots_d[i].valid;
        end
`ifdef DOSE_SCHED_MISSED_EN
        if (timeout_s) begin
            inc_s = inc_s + 8'd1;
        end else begin
            inc_s = inc_s;
        end
`endif
    end

    // Main FSM; the winner is latched on entry to ALERT.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        alarm_id_d = alarm_id_q;
        to_cnt_d   = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && any_valid_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (grant_valid_s) begin
                    state_d    = ST_ALERT;
                    win_d      = grant_idx_s;
                    alarm_id_d = ID_W'(slots_q[grant_idx_s].id);
                    to_cnt_d   = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ALERT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (ack_en_s || timeout_s) begin
                    state_d  = ST_RUN;
                    last_d   = win_q;
                    to_cnt_d = '0;
                end else if (tick_1s) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end else begin
                    to_cnt_d = to_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= IDX_W'(NUM_SLOTS - 1);
            win_q      <= '0;
            alarm_id_q <= '0;
            to_cnt_q   <= '0;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            win_q      <= win_d;
            alarm_id_q <= alarm_id_d;
            to_cnt_q   <= to_cnt_d;
            running_q  <= (state_d != ST_IDLE);
            alarm_q    <= (state_d == ST_ALERT);
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

`ifdef DOSE_SCHED_MISSED_EN
    // Saturating missed-dose accumulation.
    always_comb begin
        miss_sum_s = 9'(missed_q) + 9'(inc_s);
        if (miss_sum_s > 9'd255) begin
            missed_d = 8'd255;
        end else begin
            missed_d = miss_sum_s[7:0];
        end
    end

    // Missed counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            missed_q <= 8'd0;
        end else begin
            missed_q <= missed_d;
        end
    end

    assign missed_count = missed_q;
`endif

    assign running    = running_q;
    assign alarm      = alarm_q;
    assign alarm_id   = alarm_id_q;
    assign alarm_slot = win_q;
    assign due_mask   = due_s;

endmodule

// File: tb/tb_dose_scheduler.sv
// Bench for dose_scheduler: directed scenarios plus random traffic against a
// behavioural slot/alarm model.
module tb_dose_scheduler;

    localparam int N   = 4;
    localparam int SPU = 2;
    localparam int TO  = 3;

    logic       clk = 1'b0;
    logic       reset, tick_1s, load, start, stop, ack;
    logic [1:0] load_slot;
    logic [3:0] load_id, load_int;
    logic       running, alarm;
    logic [3:0] alarm_id;
    logic [1:0] alarm_slot;
    logic [3:0] due_mask;
`ifdef DOSE_SCHED_MISSED_EN
    logic [7:0] missed_count;
`endif

    int n_vec = 0;
    int n_miscmp = 0;

    // Reference model: mode 0 idle, 1 running, 2 alarm shown.
    int m_valid [N];
    int m_id    [N];
    int m_int   [N];
    int m_cnt   [N];
    int m_due   [N];
    int m_mode, m_last, m_win, m_wid, m_tcnt, m_miss;

    always #5 clk = ~clk;

    dose_scheduler #(
        .NUM_SLOTS     (N),
        .ID_W          (4),
        .INT_W         (4),
        .SEC_PER_UNIT  (SPU),
        .ALERT_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1s      (tick_1s),
        .load         (load),
        .load_slot    (load_slot),
        .load_id      (load_id),
        .load_int     (load_int),
        .start        (start),
        .stop         (stop),
        .ack          (ack),
        .running      (running),
        .alarm        (alarm),
        .alarm_id     (alarm_id),
        .alarm_slot   (alarm_slot),
        .due_mask     (due_mask)
`ifdef DOSE_SCHED_MISSED_EN
        ,
        .missed_count (missed_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic bump_miss();
        if (m_miss < 255) m_miss++;
    endtask

    task automatic model_step();
        int s;
        bit found;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_id[i] = 0; m_int[i] = 0; m_cnt[i] = 0; m_due[i] = 0;
            end
            m_mode = 0; m_last = N - 1; m_win = 0; m_wid = 0; m_tcnt = 0; m_miss = 0;
            return;
        end
        if (m_mode == 0) begin
            if (load) begin
                s = int'(load_slot);
                m_valid[s] = (load_int != 0);
                m_id[s]    = int'(load_id);
                m_int[s]   = int'(load_int);
                m_cnt[s]   = int'(load_int) * SPU;
                m_due[s]   = 0;
            end
            if (start) begin
                for (int i = 0; i < N; i++) if (m_valid[i] != 0) m_mode = 1;
            end
            return;
        end
        if (stop) begin
            m_mode = 0;
            return;
        end
        if (m_mode == 1) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                s = (m_last + k) % N;
                if (!found && m_due[s] != 0) begin
                    found = 1; m_mode = 2; m_win = s; m_wid = m_id[s]; m_tcnt = 0;
                end
            end
        end else begin
            if (ack) begin
                m_due[m_win] = 0; m_last = m_win; m_mode = 1;
            end else if (tick_1s && m_tcnt == TO - 1) begin
                m_due[m_win] = 0; m_last = m_win; m_mode = 1; bump_miss();
            end else if (tick_1s) begin
                m_tcnt++;
            end
        end
        if (tick_1s) begin
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] != 0) begin
                    if (m_cnt[i] > 1) m_cnt[i]--;
                    else begin
                        m_cnt[i] = m_int[i] * SPU;
                        if (m_due[i] != 0) bump_miss();
                        m_due[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        int mask;
        mask = 0;
        for (int i = 0; i < N; i++) if (m_due[i] != 0) mask |= (1 << i);
        check_eq("running", 32'(running), 32'(m_mode != 0));
        check_eq("alarm", 32'(alarm), 32'(m_mode == 2));
        check_eq("alarm_slot", 32'(alarm_slot), 32'(m_win));
        check_eq("alarm_id", 32'(alarm_id), 32'(m_wid));
        check_eq("due_mask", 32'(due_mask), 32'(mask));
`ifdef DOSE_SCHED_MISSED_EN
        check_eq("missed_count", 32'(missed_count), 32'(m_miss));
`endif
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0; tick_1s = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1;
        do_cycle();
        do_cycle();
    endtask

    task automatic do_load(input int slot, input int id, input int iv);
        load = 1'b1; load_slot = 2'(slot); load_id = 4'(id); load_int = 4'(iv);
        do_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        do_cycle();
    endtask

    initial begin
        reset = 1'b0; tick_1s = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
        load_slot = 2'd0; load_id = 4'd0; load_int = 4'd0;
        m_mode = 0; m_last = N - 1; m_win = 0; m_wid = 0; m_tcnt = 0; m_miss = 0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_id[i] = 0; m_int[i] = 0; m_cnt[i] = 0; m_due[i] = 0;
        end

        // Single slot: alarm two cycles after the due tick, ack drops it.
        do_reset();
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_alarm", 32'(alarm), 32'd0);
        do_load(0, 5, 1);
        start = 1'b1; do_cycle();
        pulse_tick();
        tick_1s = 1'b1; do_cycle();
        check_eq("t1_due", 32'(due_mask), 32'h1);
        check_eq("t1_alarm_early", 32'(alarm), 32'd0);
        do_cycle();
        check_eq("t1_alarm", 32'(alarm), 32'd1);
        check_eq("t1_id", 32'(alarm_id), 32'd5);
        check_eq("t1_slot", 32'(alarm_slot), 32'd0);
        ack = 1'b1; do_cycle();
        check_eq("t1_ack", 32'(alarm), 32'd0);
        pulse_tick(); pulse_tick();
        check_eq("t1_realarm", 32'(alarm), 32'd1);

        // Three slots due together, served in order 0,1,2 then wrapping to 0.
        do_reset();
        do_load(0, 1, 1); do_load(1, 2, 1); do_load(2, 3, 1);
        start = 1'b1; do_cycle();
        pulse_tick(); pulse_tick();
        check_eq("t2_mask", 32'(due_mask), 32'h7);
        check_eq("t2_first", 32'(alarm_slot), 32'd0);
        ack = 1'b1; do_cycle(); do_cycle();
        check_eq("t2_second", 32'(alarm_slot), 32'd1);
        ack = 1'b1; do_cycle(); do_cycle();
        check_eq("t2_third", 32'(alarm_slot), 32'd2);
        check_eq("t2_third_id", 32'(alarm_id), 32'd3);
        ack = 1'b1; do_cycle(); do_cycle();
        check_eq("t2_quiet", 32'(alarm), 32'd0);
        pulse_tick(); pulse_tick();
        check_eq("t2_wrap", 32'(alarm_slot), 32'd0);

        // Timeout after three unacknowledged ticks.
        do_reset();
        do_load(0, 9, 2);
        start = 1'b1; do_cycle();
        for (int i = 0; i < 4; i++) pulse_tick();
        pulse_tick(); pulse_tick();
        check_eq("t3_held", 32'(alarm), 32'd1);
        tick_1s = 1'b1; do_cycle();
        check_eq("t3_drop", 32'(alarm), 32'd0);
        check_eq("t3_due", 32'(due_mask), 32'h0);
`ifdef DOSE_SCHED_MISSED_EN
        check_eq("t3_missed", 32'(missed_count), 32'd1);
`endif

        // Ack coinciding with the third timeout tick.
        do_reset();
        do_load(0, 9, 2);
        start = 1'b1; do_cycle();
        for (int i = 0; i < 6; i++) pulse_tick();
        tick_1s = 1'b1; ack = 1'b1; do_cycle();
        check_eq("t4_drop", 32'(alarm), 32'd0);
`ifdef DOSE_SCHED_MISSED_EN
        check_eq("t4_missed", 32'(missed_count), 32'd0);
`endif

        // Stop during ALERT keeps due; start re-alarms; countdown preserved.
        do_reset();
        do_load(0, 6, 2);
        start = 1'b1; do_cycle();
        for (int i = 0; i < 4; i++) pulse_tick();
        stop = 1'b1; do_cycle();
        check_eq("t5_running", 32'(running), 32'd0);
        check_eq("t5_alarm", 32'(alarm), 32'd0);
        check_eq("t5_due", 32'(due_mask), 32'h1);
        start = 1'b1; do_cycle(); do_cycle();
        check_eq("t5_realarm", 32'(alarm), 32'd1);
        ack = 1'b1; do_cycle();
        for (int i = 0; i < 3; i++) pulse_tick();
        check_eq("t5_not_yet", 32'(due_mask), 32'h0);
        pulse_tick();
        check_eq("t5_next", 32'(alarm), 32'd1);

        // Load while running is ignored; reset mid-alarm; start with nothing loaded.
        ack = 1'b1; do_cycle();
        do_load(1, 3, 1);
        pulse_tick(); pulse_tick();
        check_eq("t6_load_ignored", 32'(due_mask), 32'h0);
        pulse_tick(); pulse_tick();
        check_eq("t6_alarm", 32'(alarm), 32'd1);
        do_reset();
        check_eq("t6_rst_alarm", 32'(alarm), 32'd0);
        check_eq("t6_rst_mask", 32'(due_mask), 32'h0);
        check_eq("t6_rst_id", 32'(alarm_id), 32'd0);
        start = 1'b1; do_cycle();
        check_eq("t6_empty_start", 32'(running), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            tick_1s   = ($urandom_range(0, 2) == 0);
            load      = ($urandom_range(0, 5) == 0);
            load_slot = 2'($urandom_range(0, 3));
            load_id   = 4'($urandom);
            load_int  = 4'($urandom_range(0, 3));
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            ack       = ($urandom_range(0, 3) == 0);
            do_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
